// File: rtl/panel_image_loader_pkg.sv
// ============================================================================
// Module  : panel_image_loader_pkg
// Purpose : Shared types and timing defaults for the front-panel image loader.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package panel_image_loader_pkg;

  localparam int          DEF_ADDR_W      = 12;
  localparam int          DEF_SETUP_CYC   = 10;
  localparam int          DEF_PULSE_CYC   = 10;
  localparam int          DEF_SETTLE_CYC  = 30;
  localparam int          DEF_RUN_TIMEOUT = 1000;
  localparam logic [11:0] DEF_START_PC    = 12'o0200;

  typedef logic [DEF_ADDR_W-1:0] word_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ACCEPT, ST_PC_SEQ, ST_DEP_SEQ, ST_START_SEQ,
    ST_RUN_WAIT_HI, ST_RUN_WAIT_LO, ST_FINISH, ST_DONE
  } loader_state_e;

  typedef enum logic {
    OP_LOADPC  = 1'b0,
    OP_DEPOSIT = 1'b1
  } press_op_e;

  typedef enum logic [1:0] {
    PH_IDLE, PH_SETUP, PH_PULSE, PH_SETTLE
  } press_phase_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/panel_image_loader_press.sv
// ============================================================================
// Module  : press_sequencer
// Purpose : One front-panel button press: switches set, button pulsed, settle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module press_sequencer
  import panel_image_loader_pkg::*;
#(
  parameter int SW_W       = DEF_ADDR_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic            go,
  input  press_op_e       op,
  input  logic [SW_W-1:0] sw_value,
  output logic [SW_W-1:0] sw,
  output logic            load_pc_btn,
  output logic            deposit_btn,
  output logic            release_pulse,
  output logic            done_pulse
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, SETTLE_CYC) + 1);
  localparam logic [CNT_W-1:0] C_SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  press_phase_e     r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SW_W-1:0]  r_sw;
  press_op_e        r_op;
  logic             w_done, w_release, w_take;

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_done      = 1'b0;
    w_release   = 1'b0;
    case (r_phase)
      PH_IDLE:   w_cnt_nxt = '0;
      PH_SETUP:  if (r_cnt == C_SETUP_LAST) begin
                   w_phase_nxt = PH_PULSE;
                   w_cnt_nxt   = '0;
                 end
      PH_PULSE:  if (r_cnt == C_PULSE_LAST) begin
                   w_release   = 1'b1;
                   w_phase_nxt = PH_SETTLE;
                   w_cnt_nxt   = '0;
                 end
      PH_SETTLE: if (r_cnt == C_SETTLE_LAST) begin
                   w_done      = 1'b1;
                   w_phase_nxt = PH_IDLE;
                   w_cnt_nxt   = '0;
                 end
      default:   w_phase_nxt = PH_IDLE;
    endcase
    // A new press may be chained onto the final settle cycle with no gap.
    w_take = go && ((r_phase == PH_IDLE) || w_done);
    if (w_take) begin
      w_phase_nxt = PH_SETUP;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_sw    <= '0;
      r_op    <= OP_LOADPC;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_take) begin
        r_sw <= sw_value;
        r_op <= op;
      end
    end
  end

  assign sw            = r_sw;
  assign load_pc_btn   = (r_phase == PH_PULSE) && (r_op == OP_LOADPC);
  assign deposit_btn   = (r_phase == PH_PULSE) && (r_op == OP_DEPOSIT);
  assign release_pulse = w_release;
  assign done_pulse    = w_done;

endmodule

`default_nettype wire

// File: rtl/panel_image_loader.sv
// ============================================================================
// Module  : panel_image_loader
// Purpose : Plays a streamed (address,data) image into the front panel, then
//           optionally loads the start PC and runs until the CPU halts.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module panel_image_loader
  import panel_image_loader_pkg::*;
#(
  parameter int              ADDR_W      = DEF_ADDR_W,
  parameter int              DATA_W      = DEF_ADDR_W,
  parameter int              SETUP_CYC   = DEF_SETUP_CYC,
  parameter int              PULSE_CYC   = DEF_PULSE_CYC,
  parameter int              SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter logic [ADDR_W-1:0] START_PC  = ADDR_W'(DEF_START_PC),
  parameter bit              AUTO_RUN    = 1'b1,
  parameter int              RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              start,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  input  logic              img_last,
  input  logic              run_led,
  output logic [ADDR_W:0]   sw,
  output logic              load_pc_btn,
  output logic              deposit_btn,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [ADDR_W:0]   pc_loads
);

  localparam int RT_W = $clog2(RUN_TIMEOUT + 1);
  localparam logic [RT_W-1:0] C_RT_LAST = RT_W'(RUN_TIMEOUT - 1);

  loader_state_e     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_data, r_exp_pc, w_sw_value, w_seq_sw;
  logic              r_last, r_exp_valid, r_run_sw, r_busy, r_timeout;
  logic [ADDR_W:0]   r_words, r_pcl;
  logic [RT_W-1:0]   r_run_cnt;
  logic              w_go, w_seq_release, w_seq_done, w_start_ok, w_hs, w_need_pc;
  press_op_e         w_op;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_hs       = (r_state == ST_ACCEPT) && img_valid;
  assign w_need_pc  = !r_exp_valid || (img_addr != r_exp_pc);

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_op        = OP_DEPOSIT;
    w_sw_value  = r_data;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_ACCEPT;
      ST_ACCEPT: if (img_valid) begin
        w_go = 1'b1;
        if (w_need_pc) begin
          w_op        = OP_LOADPC;
          w_sw_value  = img_addr;
          w_state_nxt = ST_PC_SEQ;
        end else begin
          w_sw_value  = img_data;
          w_state_nxt = ST_DEP_SEQ;
        end
      end
      ST_PC_SEQ: if (w_seq_done) begin
        w_go        = 1'b1;
        w_state_nxt = ST_DEP_SEQ;
      end
      ST_DEP_SEQ: if (w_seq_done) begin
        if (!r_last) begin
          w_state_nxt = ST_ACCEPT;
        end else if (AUTO_RUN) begin
          w_go        = 1'b1;
          w_op        = OP_LOADPC;
          w_sw_value  = START_PC;
          w_state_nxt = ST_START_SEQ;
        end else begin
          w_state_nxt = ST_FINISH;
        end
      end
      ST_START_SEQ:   if (w_seq_done) w_state_nxt = ST_RUN_WAIT_HI;
      ST_RUN_WAIT_HI: if (run_led) w_state_nxt = ST_RUN_WAIT_LO;
                      else if (r_run_cnt == C_RT_LAST) w_state_nxt = ST_FINISH;
      ST_RUN_WAIT_LO: if (!run_led) w_state_nxt = ST_FINISH;
      ST_FINISH:      w_state_nxt = ST_DONE;
      default:        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_exp_pc    <= '0;
      r_exp_valid <= 1'b0;
      r_run_sw    <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_words     <= '0;
      r_pcl       <= '0;
      r_run_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_words     <= '0;
        r_pcl       <= '0;
        r_timeout   <= 1'b0;
        r_exp_valid <= 1'b0;
        r_busy      <= 1'b1;
      end
      if (w_hs) begin
        r_addr <= img_addr;
        r_data <= img_data;
        r_last <= img_last;
      end
      // Counters step on button release and hold at all-ones.
      if (w_seq_release) begin
        if (r_state == ST_DEP_SEQ) r_words <= (&r_words) ? r_words : r_words + 1'b1;
        else                       r_pcl   <= (&r_pcl)   ? r_pcl   : r_pcl + 1'b1;
      end
      if ((r_state == ST_DEP_SEQ) && w_seq_done) begin
        r_exp_pc    <= r_addr + 1'b1;
        r_exp_valid <= 1'b1;
      end
      if ((r_state == ST_START_SEQ) && w_seq_done) r_run_sw <= 1'b1;
      r_run_cnt <= (r_state == ST_RUN_WAIT_HI) ? r_run_cnt + 1'b1 : '0;
      if ((r_state == ST_RUN_WAIT_HI) && !run_led && (r_run_cnt == C_RT_LAST)) begin
        r_timeout <= 1'b1;
        r_run_sw  <= 1'b0;
      end
      if ((r_state == ST_RUN_WAIT_LO) && !run_led) r_run_sw <= 1'b0;
      if (r_state == ST_FINISH) r_busy <= 1'b0;
    end
  end

  press_sequencer #(
    .SW_W      (ADDR_W),
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .SETTLE_CYC(SETTLE_CYC)
  ) u_press (
    .clock        (clock),
    .resetN       (resetN),
    .go           (w_go),
    .op           (w_op),
    .sw_value     (w_sw_value),
    .sw           (w_seq_sw),
    .load_pc_btn  (load_pc_btn),
    .deposit_btn  (deposit_btn),
    .release_pulse(w_seq_release),
    .done_pulse   (w_seq_done)
  );

  assign img_ready    = (r_state == ST_ACCEPT);
  assign sw           = {r_run_sw, w_seq_sw};
  assign busy         = r_busy;
  assign done         = (r_state == ST_FINISH);
  assign timeout_err  = r_timeout;
  assign words_loaded = r_words;
  assign pc_loads     = r_pcl;

endmodule

`default_nettype wire

// File: tb/tb_panel_image_loader.sv
// ============================================================================
// Module  : tb_panel_image_loader
// Purpose : Self-checking bench with a front-panel memory model and scoreboard.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_panel_image_loader;

  localparam int SETUP = 10, PULSE = 10, SETTLE = 30, RUN_TO = 20;
  localparam int GAP_SKIP = SETUP + PULSE + SETTLE + 1;
  localparam int GAP_PC   = 2 * (SETUP + PULSE + SETTLE) + 1;

  logic        clock, resetN, start, img_valid, img_ready, img_last, run_led;
  logic [11:0] img_addr, img_data;
  logic [12:0] sw, words_loaded, pc_loads;
  logic        load_pc_btn, deposit_btn, busy, done, timeout_err;

  panel_image_loader #(
    .ADDR_W(12), .DATA_W(12), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
    .SETTLE_CYC(SETTLE), .START_PC(12'o0200), .AUTO_RUN(1'b1), .RUN_TIMEOUT(RUN_TO)
  ) dut (
    .clock(clock), .resetN(resetN), .start(start), .img_valid(img_valid),
    .img_ready(img_ready), .img_addr(img_addr), .img_data(img_data),
    .img_last(img_last), .run_led(run_led), .sw(sw), .load_pc_btn(load_pc_btn),
    .deposit_btn(deposit_btn), .busy(busy), .done(done), .timeout_err(timeout_err),
    .words_loaded(words_loaded), .pc_loads(pc_loads)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int cyc = 0, last_dep = 0, dep_rise = 0, overlap = 0, led_cnt = 0;
  bit led_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0o expected=%0o", name, act, exp);
    end
  endtask

  // Front-panel model: load PC latches switches, deposit writes memory and bumps PC.
  typedef struct { logic [11:0] addr; logic [11:0] data; int gap; } exp_t;
  exp_t        sb[$];
  logic [11:0] fp_pc = '0;
  logic [11:0] mem [4096];

  always @(posedge clock) cyc++;

  always @(posedge load_pc_btn) fp_pc = sw[11:0];

  always @(posedge deposit_btn) begin
    exp_t e;
    chk("dep_expected", int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("dep_addr", fp_pc, e.addr);
      chk("dep_data", sw[11:0], e.data);
      if (e.gap != 0) chk("dep_gap", cyc - last_dep, e.gap);
    end
    last_dep = cyc;
    dep_rise = cyc;
    mem[fp_pc] = sw[11:0];
    fp_pc = fp_pc + 12'd1;
  end

  always @(negedge deposit_btn) if (resetN) chk("dep_width", cyc - dep_rise, PULSE);

  // CPU model: run LED rises a few cycles after the run switch, then drops on HLT.
  always @(negedge clock) begin
    if (load_pc_btn && deposit_btn) overlap++;
    if (!resetN || !led_en || !sw[12]) begin
      led_cnt = 0;
      run_led = 1'b0;
    end else begin
      led_cnt++;
      run_led = (led_cnt >= 5) && (led_cnt < 13);
    end
  end

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] a, input logic [11:0] d, input bit l);
    int k;
    @(negedge clock);
    img_valid = 1'b1; img_addr = a; img_data = d; img_last = l;
    k = 0;
    while (!img_ready && k < 300) begin
      @(negedge clock);
      k++;
    end
    chk("accept_in_time", int'(img_ready), 1);
    @(posedge clock);
    #1 img_valid = 1'b0; img_last = 1'b0;
  endtask

  task automatic wait_done(output int run_rise, output int to_rise, output bit led_seen,
                           output bit got);
    run_rise = -1; to_rise = -1; led_seen = 1'b0; got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clock);
      if (sw[12] && run_rise < 0) run_rise = k;
      if (timeout_err && to_rise < 0) to_rise = k;
      if (run_led) led_seen = 1'b1;
      if (done) got = 1'b1;
    end
  endtask

  typedef struct {
    logic [11:0] addr; logic [11:0] data; bit last; bit pcload; bit tmo;
  } vec_t;
  vec_t vt[12];

  initial begin
    int  run_rise, to_rise, exp_pcl, n, s0, k;
    bit  led_seen, got, first;

    // contiguous / sparse / wrap / timeout / run-to-halt sessions
    vt[0]  = '{12'o0200, 12'o7200, 0, 1, 0};
    vt[1]  = '{12'o0201, 12'o1205, 0, 0, 0};
    vt[2]  = '{12'o0202, 12'o3206, 0, 0, 0};
    vt[3]  = '{12'o0203, 12'o7402, 1, 0, 0};
    vt[4]  = '{12'o0200, 12'o7300, 0, 1, 0};
    vt[5]  = '{12'o0400, 12'o7402, 0, 1, 0};
    vt[6]  = '{12'o0201, 12'o1000, 1, 1, 0};
    vt[7]  = '{12'o7776, 12'o1111, 0, 1, 0};
    vt[8]  = '{12'o7777, 12'o2222, 0, 0, 0};
    vt[9]  = '{12'o0000, 12'o3333, 1, 0, 0};
    vt[10] = '{12'o0300, 12'o7402, 1, 1, 1};
    vt[11] = '{12'o0200, 12'o7402, 1, 1, 0};

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    resetN = 1'b0; start = 1'b0; img_valid = 1'b0; img_last = 1'b0;
    img_addr = '0; img_data = '0; run_led = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_ready", img_ready, 0);
    chk("rst_sw", sw, 0);
    chk("rst_btns", {load_pc_btn, deposit_btn}, 0);
    chk("rst_counts", {words_loaded, pc_loads}, 0);
    chk("rst_flags", {done, timeout_err}, 0);

    // Reset asserted in the middle of a load-PC pulse
    pulse_start();
    send_word(12'o0500, 12'o1234, 1'b1);
    k = 0;
    while (!load_pc_btn && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("t1_pulse_seen", load_pc_btn, 1);
    repeat (3) @(negedge clock);
    resetN = 1'b0;
    #1;
    chk("t1_btns", {load_pc_btn, deposit_btn}, 0);
    chk("t1_sw", sw, 0);
    chk("t1_busy", busy, 0);
    chk("t1_counts", {words_loaded, pc_loads}, 0);
    @(negedge clock) resetN = 1'b1;
    @(negedge clock);

    first = 1'b1; exp_pcl = 0; n = 0; s0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (first) begin
        led_en = !vt[i].tmo;
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_clears_tmo", timeout_err, 0);
        chk("start_counts", {words_loaded, pc_loads}, 0);
        exp_pcl = 0; n = 0; s0 = i;
      end
      if (vt[i].pcload) exp_pcl++;
      n++;
      sb.push_back('{vt[i].addr, vt[i].data,
                     first ? 0 : (vt[i].pcload ? GAP_PC : GAP_SKIP)});
      send_word(vt[i].addr, vt[i].data, vt[i].last);
      first = 1'b0;
      if (vt[i].last) begin
        if (vt[i].tmo) begin
          repeat (30) @(negedge clock);
          pulse_start();
        end
        wait_done(run_rise, to_rise, led_seen, got);
        chk("done_seen", got, 1);
        chk("words_loaded", words_loaded, n);
        chk("pc_loads", pc_loads, exp_pcl + 1);
        chk("timeout_err", timeout_err, vt[i].tmo);
        chk("run_sw_low", sw[12], 0);
        chk("run_sw_raised", int'(run_rise >= 0), 1);
        chk("led_seen", led_seen, !vt[i].tmo);
        if (vt[i].tmo) chk("timeout_cycles", to_rise - run_rise, RUN_TO);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        chk("busy_cleared", busy, 0);
        for (int j = s0; j <= i; j++) chk("mem", mem[vt[j].addr], vt[j].data);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        first = 1'b1;
      end
    end

    chk("btn_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
